clk_divider_multi: RTL and testbench

Parametrised multi-channel clock divider: the successor to the fixed three-output divider, with per-channel divisors, a global simulation-speed scale, per-channel enable, phase resynchronisation and an asynchronous reset. It sits at the top of the design, between the board oscillator and the display-refresh, stopwatch and blink logic. Each channel produces a registered 50 % duty square wave and a one-cycle tick pulse aligned with that wave's rising edge.

---
 rtl/clk_divider_multi.sv | 90 +++++++++
 tb/tb_clk_divider_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// -----------------------------------------------------------------------------
// clk_divider_multi
//   Parametrised multi-channel clock divider. Each channel divides clk_cd by
//   2*H_i (H_i = HALF_i / SIM_DIV, clamped to at least 1). It produces a
//   registered 50 % square wave and a one-cycle tick that coincides with the
//   wave's rising edge.
//
// Parameters
//   NUM_CH   : number of channels (1..8)
//   CNT_W    : half-period counter width / packed divisor field width
//   HALF_VEC : packed half-periods, channel i at [i*CNT_W +: CNT_W]
//   SIM_DIV  : global divisor applied to every half-period (simulation speed-up)
//
// Ports
//   clk_cd     in  1       system clock, rising edge
//   rst_n_cd   in  1       asynchronous active-low reset
//   en_cd      in  NUM_CH  per-channel count enable
//   sync_cd    in  1       synchronous phase-align strobe, clears every channel
//   clk_out_cd out NUM_CH  divided square waves (registered)
//   tick_cd    out NUM_CH  one-cycle pulse on each rising edge of clk_out_cd
// -----------------------------------------------------------------------------
module clk_divider_multi #(
  parameter int                        NUM_CH   = 3,
  parameter int                        CNT_W    = 27,
  parameter logic [NUM_CH*CNT_W-1:0]   HALF_VEC = {27'd25000000, 27'd50000000, 27'd100000},
  parameter int                        SIM_DIV  = 1
) (
  input  logic              clk_cd,
  input  logic              rst_n_cd,
  input  logic [NUM_CH-1:0] en_cd,
  input  logic              sync_cd,
  output logic [NUM_CH-1:0] clk_out_cd,
  output logic [NUM_CH-1:0] tick_cd
);

  // Elaboration-time parameter sanity. Each HALF_i already fits CNT_W bits
  // because it is taken from a CNT_W-wide field of HALF_VEC.
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $fatal(1, "clk_divider_multi: NUM_CH must be in 1..8");
  end
  if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
    $fatal(1, "clk_divider_multi: CNT_W must be in 1..64");
  end
  if (SIM_DIV < 1) begin : g_bad_sim_div
    $fatal(1, "clk_divider_multi: SIM_DIV must be at least 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Effective half-period computed in 64 bits so the division and the clamp
    // never truncate, then narrowed to the terminal count H_i - 1.
    localparam logic [63:0]      HALF_L = 64'(HALF_VEC[i*CNT_W +: CNT_W]);
    localparam logic [63:0]      DIV_L  = 64'(SIM_DIV);
    localparam logic [63:0]      QUOT_L = HALF_L / DIV_L;
    localparam logic [63:0]      H_L    = (QUOT_L == 64'd0) ? 64'd1 : QUOT_L;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(H_L - 64'd1);

    logic [CNT_W-1:0] cnt;
    logic             clk_q;
    logic             tick_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_cd or negedge rst_n_cd) begin
      if (!rst_n_cd) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (sync_cd) begin
        // Phase align overrides enable: all channels restart from zero.
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (!en_cd[i]) begin
        tick_q <= 1'b0;
      end else if (cnt == LAST) begin
        cnt    <= '0;
        clk_q  <= ~clk_q;
        // Tick only on the 0 -> 1 transition of the output.
        tick_q <= ~clk_q;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        tick_q <= 1'b0;
      end
    end

    assign clk_out_cd[i] = clk_q;
    assign tick_cd[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_multi
//   Drives two divider instances with the same stimulus: one with
//   HALF_VEC = {4,3,1}, SIM_DIV = 1 and one with HALF_VEC = {8,6,1},
//   SIM_DIV = 2. Both must follow the same reference model with H = {4,3,1}.
//   The model counts enabled edges since the last clear per channel and
//   derives the wave and tick from that count arithmetically.
// -----------------------------------------------------------------------------
module tb_clk_divider_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 27;

  logic              clk_cd;
  logic              rst_n_cd;
  logic [NUM_CH-1:0] en_cd;
  logic              sync_cd;
  logic [NUM_CH-1:0] clk_out_a, tick_a;
  logic [NUM_CH-1:0] clk_out_b, tick_b;

  clk_divider_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .HALF_VEC({27'd4, 27'd3, 27'd1}),
    .SIM_DIV (1)
  ) u_dut_a (
    .clk_cd    (clk_cd),
    .rst_n_cd  (rst_n_cd),
    .en_cd     (en_cd),
    .sync_cd   (sync_cd),
    .clk_out_cd(clk_out_a),
    .tick_cd   (tick_a)
  );

  clk_divider_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .HALF_VEC({27'd8, 27'd6, 27'd1}),
    .SIM_DIV (2)
  ) u_dut_b (
    .clk_cd    (clk_cd),
    .rst_n_cd  (rst_n_cd),
    .en_cd     (en_cd),
    .sync_cd   (sync_cd),
    .clk_out_cd(clk_out_b),
    .tick_cd   (tick_b)
  );

  initial clk_cd = 1'b0;
  always #5 clk_cd = ~clk_cd;

  int errors = 0;
  int checks = 0;

  // Reference model: effective half-periods and enabled-edge counts.
  int h [NUM_CH] = '{1, 3, 4};
  int e [NUM_CH];
  bit t [NUM_CH];

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = ((e[i] / h[i]) % 2) == 1;
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = t[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      e[i] = 0;
      t[i] = 1'b0;
    end
  endtask

  // One rising edge as the specification describes it.
  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_cd) begin
        e[i] = 0;
        t[i] = 1'b0;
      end else if (!en_cd[i]) begin
        t[i] = 1'b0;
      end else begin
        e[i] = e[i] + 1;
        t[i] = (e[i] % (2 * h[i])) == h[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs,
                     input logic [NUM_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_clk_a"},  clk_out_a, exp_clk());
    chk({tag, "_tick_a"}, tick_a,    exp_tick());
    chk({tag, "_clk_b"},  clk_out_b, exp_clk());
    chk({tag, "_tick_b"}, tick_b,    exp_tick());
  endtask

  // Advance one edge, update the model, sample 1 ns after the edge.
  task automatic step(input string tag);
    @(posedge clk_cd);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    bit found;

    // ---------------- Reset state ----------------
    rst_n_cd = 1'b0;
    en_cd    = '0;
    sync_cd  = 1'b0;
    model_clear();
    #23;
    check_all("reset");
    @(negedge clk_cd);
    en_cd    = 3'b111;
    rst_n_cd = 1'b1;

    // ---------------- Free run ----------------
    for (int n = 1; n <= 24; n++) begin
      step("freerun");
      if (n == 3) chk("edge3_tick", tick_a, 3'b011);
      if (n == 4) begin
        chk("edge4_tick", tick_a, 3'b100);
        chk("edge4_clk", clk_out_a, 3'b110);
      end
      if (n == 9)  chk("edge9_tick", tick_a, 3'b011);
      if (n == 12) chk("edge12_tick", tick_b, 3'b100);
    end

    // ---------------- Enable pause on channel 2 ----------------
    // Free run ended with e[2] = 24 (multiple of 8), so two edges later the
    // channel-2 counter is at 2.
    step("pre_pause");
    step("pre_pause");
    en_cd[2] = 1'b0;
    for (int n = 0; n < 5; n++) step("pause");
    en_cd[2] = 1'b1;
    for (int n = 0; n < 10; n++) step("resume");

    // ---------------- Resync pulse ----------------
    sync_cd = 1'b1;
    step("sync_edge");
    chk("sync_clear", clk_out_a, 3'b000);
    sync_cd = 1'b0;
    step("sync_k1");
    chk("sync_k1_tick", tick_a, 3'b001);
    for (int n = 0; n < 10; n++) step("post_sync");

    // ---------------- Asynchronous reset mid-count ----------------
    found = 1'b0;
    for (int n = 0; n < 24 && !found; n++) begin
      step("seek110");
      if (exp_clk() == 3'b110) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL seek110 observed=not_reached expected=reached");
    end
    #2;
    rst_n_cd = 1'b0;
    model_clear();
    #1;
    check_all("async_rst");
    #2;
    rst_n_cd = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step("after_rst");
      if (n == 4) chk("after_rst_edge4", tick_a, 3'b100);
    end

    // ---------------- Sync beats enable ----------------
    en_cd   = 3'b000;
    sync_cd = 1'b1;
    for (int n = 0; n < 4; n++) step("sync_no_en");
    sync_cd = 1'b0;
    en_cd   = 3'b111;
    for (int n = 0; n < 8; n++) step("after_sync_no_en");

    // ---------------- Random stimulus ----------------
    for (int n = 0; n < 400; n++) begin
      en_cd   = NUM_CH'($urandom);
      sync_cd = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 63) == 0) begin
        #3;
        rst_n_cd = 1'b0;
        model_clear();
        #1;
        check_all("rand_rst");
        rst_n_cd = 1'b1;
      end
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
